watermark_block_engine: RTL and testbench
=========================================

// Module: watermark_block_engine
// PURPOSE
//  Parametrised successor of the visible-watermarking datapath. Walks a primary image block by block,
//  pairs each pixel with the co-located watermark-block pixel, and blends them with per-frame
//  alpha/beta coefficients. Supports N colour channels. Sits between the APB data bank read port and
//  the downstream pixel sink, using a valid/ready stream with block and frame markers.
// PARAMETERS
//  DATA_DEPTH   8   bits per channel sample
//  CHANNELS     1   channels per pixel word, packed LSB-first
//  ADDR_DEPTH   20  data-bank word address width
//  BLOCK_DEPTH  7   width of block side M (max 127)
//  BLKCNT_W     7   width of block count (max 127 blocks)
//  COEF_W       8   alpha/beta width; fixed-point with COEF_W fraction bits
// PORTS
//  clk            in   1                    system clock
//  rst            in   1                    synchronous active-high reset
//  start          in   1                    1-cycle pulse; begin a frame (ignored unless IDLE)
//  cfg_m          in   BLOCK_DEPTH          block side M (pixels/row)
//  cfg_blocks     in   BLKCNT_W             number of blocks in frame
//  cfg_pri_base   in   ADDR_DEPTH           word address of first primary pixel
//  cfg_wm_base    in   ADDR_DEPTH           word address of watermark block (M*M words, reused per block)
//  cfg_alpha      in   COEF_W               primary weight
//  cfg_beta       in   COEF_W               watermark weight
//  mem_rd_en      out  1                    bank read strobe
//  mem_addr       out  ADDR_DEPTH           bank read address
//  mem_rd_data    in   CHANNELS*DATA_DEPTH  read data, valid exactly 1 cycle after mem_rd_en
//  pix_valid      out  1                    blended pixel available
//  pix_ready      in   1                    sink accepts pixel
//  pix_data       out  CHANNELS*DATA_DEPTH  blended pixel
//  pix_blk_last   out  1                    pixel is last of its block
//  pix_last       out  1                    pixel is last of frame
//  busy           out  1                    high from start accept until done
//  done           out  1                    1-cycle pulse after final handshake
// BEHAVIOUR
//  - Reset (rst=1 at posedge): state IDLE; counters cleared; all outputs 0. Applies mid-frame: frame
//    abandoned, no done pulse, pix_valid drops on the next edge.
//  - On IDLE && start, cfg_* are latched; later cfg changes have no effect on the current frame.
//  - FSM: IDLE -> RD_P -> RD_W -> CALC -> OUT -> (RD_P | FIN) ; FIN -> IDLE.
//    RD_P:  mem_rd_en=1, mem_addr = pri_base + pix_idx (frame-linear index).
//    RD_W:  latch mem_rd_data as P; mem_rd_en=1, mem_addr = wm_base + blk_idx (index within block).
//    CALC:  latch W; compute the per-channel result into the output register.
//    OUT:   pix_valid=1; pix_data, pix_blk_last and pix_last held stable while !pix_ready.
//           On pix_ready: pix_idx++, blk_idx++ (wraps to 0 at M*M-1); go to FIN on the last pixel,
//           else RD_P.
//    FIN:   done=1 for one cycle; busy=0 on the following cycle.
//  - Latency: first pix_valid 4 cycles after start is accepted; throughput is 1 pixel per 4 cycles
//    with pix_ready held high.
//  - Arithmetic per channel:
//      s = alpha*P + beta*W + 2^(COEF_W-1)   (width DATA_DEPTH+COEF_W+1, unsigned)
//      r = s >> COEF_W
//  - pix_blk_last = (blk_idx == M*M-1); pix_last = pix_blk_last && (block count == cfg_blocks-1).
//  - cfg_m==0 or cfg_blocks==0: IDLE -> FIN directly. No reads, no pixels, done pulse 2 cycles after start.
//  - start while busy is ignored. busy=1 from the cycle after start through FIN.
// CONFIGURATION
//  WM_SATURATE_EN defined: each channel result clamps to 2^DATA_DEPTH-1 when r overflows.
//  WM_SATURATE_EN undefined: the result is truncated to the low DATA_DEPTH bits (wraps).
// TESTING
//  1. M=2, blocks=1, alpha=beta=128, every P=100, W=200 -> 4 pixels of 150; pix_blk_last and
//     pix_last on the 4th pixel; done 1 cycle after its handshake.
//  2. alpha=beta=255, P=W=200 -> 255 with WM_SATURATE_EN; 142 without it.
//  3. M=2, blocks=3, pri_base=0x0A, wm_base=0x100 -> primary addresses 0x0A..0x15 in order;
//     watermark addresses cycle 0x100..0x103 three times; pix_blk_last on pixels 4, 8 and 12.
//  4. Hold pix_ready=0 for 5 cycles on pixel 2 -> pix_data stable, no new mem_rd_en, no pixel lost.
//  5. cfg_blocks=0 -> no mem_rd_en, no pix_valid, done 2 cycles after start; start while busy ignored.
//  6. Assert rst during OUT of pixel 3 -> next edge: all outputs 0, IDLE; a fresh start runs a full frame.

Source files
------------

// File: rtl/watermark_block_engine.sv
// Block-wise visible-watermark blender: reads primary and watermark pixels from the data bank
// and streams alpha/beta-blended pixels. Optional macro WM_SATURATE_EN clamps channel overflow.
module watermark_block_engine #(
    parameter int DATA_DEPTH  = 8,
    parameter int CHANNELS    = 1,
    parameter int ADDR_DEPTH  = 20,
    parameter int BLOCK_DEPTH = 7,
    parameter int BLKCNT_W    = 7,
    parameter int COEF_W      = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [BLOCK_DEPTH-1:0]         cfg_m,
    input  logic [BLKCNT_W-1:0]            cfg_blocks,
    input  logic [ADDR_DEPTH-1:0]          cfg_pri_base,
    input  logic [ADDR_DEPTH-1:0]          cfg_wm_base,
    input  logic [COEF_W-1:0]              cfg_alpha,
    input  logic [COEF_W-1:0]              cfg_beta,
    output logic                           mem_rd_en,
    output logic [ADDR_DEPTH-1:0]          mem_addr,
    input  logic [CHANNELS*DATA_DEPTH-1:0] mem_rd_data,
    output logic                           pix_valid,
    input  logic                           pix_ready,
    output logic [CHANNELS*DATA_DEPTH-1:0] pix_data,
    output logic                           pix_blk_last,
    output logic                           pix_last,
    output logic                           busy,
    output logic                           done
);

    localparam int PW  = CHANNELS * DATA_DEPTH;
    localparam int BIW = 2 * BLOCK_DEPTH;
    localparam int SW  = DATA_DEPTH + COEF_W + 1;
    localparam logic [SW-1:0] ROUND = SW'(1) << (COEF_W - 1);

    typedef enum logic [2:0] {IDLE, RD_P, RD_W, CALC, OUT, FIN} state_t;

    state_t                state;
    logic [ADDR_DEPTH-1:0] pri_base_q;
    logic [ADDR_DEPTH-1:0] wm_base_q;
    logic [COEF_W-1:0]     alpha_q;
    logic [COEF_W-1:0]     beta_q;
    logic [BLKCNT_W-1:0]   blocks_q;
    logic [BIW-1:0]        mm_last_q;
    logic [ADDR_DEPTH-1:0] pix_idx;
    logic [BIW-1:0]        blk_idx;
    logic [BLKCNT_W-1:0]   blk_cnt;
    logic [PW-1:0]         p_q;

    function automatic logic [PW-1:0] blend(input logic [PW-1:0] p, input logic [PW-1:0] w,
                                            input logic [COEF_W-1:0] a, input logic [COEF_W-1:0] b);
        logic [SW-1:0]         s;
        logic [DATA_DEPTH:0]   r;
        blend = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            s = SW'(a) * SW'(p[c*DATA_DEPTH +: DATA_DEPTH])
              + SW'(b) * SW'(w[c*DATA_DEPTH +: DATA_DEPTH]) + ROUND;
            r = (DATA_DEPTH + 1)'(s >> COEF_W);
`ifdef WM_SATURATE_EN
            blend[c*DATA_DEPTH +: DATA_DEPTH] = r[DATA_DEPTH] ? '1 : DATA_DEPTH'(r);
`else
            blend[c*DATA_DEPTH +: DATA_DEPTH] = DATA_DEPTH'(r);
`endif
        end
    endfunction

    // NOTE: every register here is state, so all assignments are non-blocking and all are reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pri_base_q   <= '0;
            wm_base_q    <= '0;
            alpha_q      <= '0;
            beta_q       <= '0;
            blocks_q     <= '0;
            mm_last_q    <= '0;
            pix_idx      <= '0;
            blk_idx      <= '0;
            blk_cnt      <= '0;
            p_q          <= '0;
            mem_rd_en    <= 1'b0;
            mem_addr     <= '0;
            pix_valid    <= 1'b0;
            pix_data     <= '0;
            pix_blk_last <= 1'b0;
            pix_last     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pri_base_q <= cfg_pri_base;
                        wm_base_q  <= cfg_wm_base;
                        alpha_q    <= cfg_alpha;
                        beta_q     <= cfg_beta;
                        blocks_q   <= cfg_blocks;
                        mm_last_q  <= BIW'(cfg_m) * BIW'(cfg_m) - BIW'(1);
                        pix_idx    <= '0;
                        blk_idx    <= '0;
                        blk_cnt    <= '0;
                        busy       <= 1'b1;
                        if (cfg_m == '0 || cfg_blocks == '0) begin
                            state <= FIN;
                        end else begin
                            state     <= RD_P;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= cfg_pri_base;
                        end
                    end
                end
                RD_P: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= wm_base_q + ADDR_DEPTH'(blk_idx);
                    state     <= RD_W;
                end
                RD_W: begin
                    p_q       <= mem_rd_data;
                    mem_rd_en <= 1'b0;
                    state     <= CALC;
                end
                CALC: begin
                    pix_data     <= blend(p_q, mem_rd_data, alpha_q, beta_q);
                    pix_valid    <= 1'b1;
                    pix_blk_last <= (blk_idx == mm_last_q);
                    pix_last     <= (blk_idx == mm_last_q) && (blk_cnt == blocks_q - BLKCNT_W'(1));
                    state        <= OUT;
                end
                OUT: begin
                    if (pix_ready) begin
                        pix_valid    <= 1'b0;
                        pix_blk_last <= 1'b0;
                        pix_last     <= 1'b0;
                        pix_idx      <= pix_idx + ADDR_DEPTH'(1);
                        if (pix_blk_last) begin
                            blk_idx <= '0;
                            blk_cnt <= blk_cnt + BLKCNT_W'(1);
                        end else begin
                            blk_idx <= blk_idx + BIW'(1);
                        end
                        if (pix_last) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state     <= RD_P;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= pri_base_q + pix_idx + ADDR_DEPTH'(1);
                        end
                    end
                end
                FIN: begin
                    // An empty frame enters FIN with done low and spends one extra cycle here
                    // raising it; a normal frame arrives with done already high.
                    if (done) begin
                        done  <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_watermark_block_engine.sv
// Randomized scoreboard bench for watermark_block_engine: a behavioural frame model fills
// expected-address and expected-pixel queues, and a negedge monitor pops and compares.
module tb_watermark_block_engine;

    localparam int DW = 8;
    localparam int CH = 2;
    localparam int AW = 20;
    localparam int BD = 7;
    localparam int BW = 7;
    localparam int CW = 8;
    localparam int PW = CH * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [BD-1:0] cfg_m;
    logic [BW-1:0] cfg_blocks;
    logic [AW-1:0] cfg_pri_base;
    logic [AW-1:0] cfg_wm_base;
    logic [CW-1:0] cfg_alpha;
    logic [CW-1:0] cfg_beta;
    logic          mem_rd_en;
    logic [AW-1:0] mem_addr;
    logic [PW-1:0] mem_rd_data = '0;
    logic          pix_valid;
    logic          pix_ready = 1'b1;
    logic [PW-1:0] pix_data;
    logic          pix_blk_last;
    logic          pix_last;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    watermark_block_engine #(
        .DATA_DEPTH(DW), .CHANNELS(CH), .ADDR_DEPTH(AW),
        .BLOCK_DEPTH(BD), .BLKCNT_W(BW), .COEF_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_m(cfg_m), .cfg_blocks(cfg_blocks),
        .cfg_pri_base(cfg_pri_base), .cfg_wm_base(cfg_wm_base),
        .cfg_alpha(cfg_alpha), .cfg_beta(cfg_beta),
        .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .pix_blk_last(pix_blk_last), .pix_last(pix_last),
        .busy(busy), .done(done)
    );

    // Data bank: one-cycle read latency
    logic [PW-1:0] mem [0:4095];
    always @(posedge clk) if (mem_rd_en) mem_rd_data <= mem[mem_addr[11:0]];

    typedef struct {
        logic [PW-1:0] data;
        logic          blk_last;
        logic          last;
    } exp_t;

    exp_t          pix_q[$];
    logic [AW-1:0] addr_q[$];

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [PW-1:0] ref_pixel(input logic [PW-1:0] p, input logic [PW-1:0] w,
                                                input int a, input int b);
        logic [PW-1:0] res = '0;
        for (int c = 0; c < CH; c++) begin
            int pc = int'(p[c*DW +: DW]);
            int wc = int'(w[c*DW +: DW]);
            int r  = (a * pc + b * wc + (1 << (CW - 1))) >> CW;
`ifdef WM_SATURATE_EN
            if (r > (1 << DW) - 1) r = (1 << DW) - 1;
`else
            r = r % (1 << DW);
`endif
            res[c*DW +: DW] = DW'(r);
        end
        return res;
    endfunction

    task automatic build_model(input int m, input int blocks, input int pri, input int wm,
                               input int a, input int b);
        int   mm    = m * m;
        int   total = mm * blocks;
        exp_t e;
        for (int k = 0; k < total; k++) begin
            addr_q.push_back(AW'(pri + k));
            addr_q.push_back(AW'(wm + k % mm));
            e.data     = ref_pixel(mem[(pri + k) % 4096], mem[(wm + k % mm) % 4096], a, b);
            e.blk_last = (k % mm == mm - 1);
            e.last     = (k == total - 1);
            pix_q.push_back(e);
        end
    endtask

    // Monitor: compares every read strobe and every pixel handshake against the queues
    int            hs_total   = 0;
    int            frame_base = 0;
    bit            exp_done   = 1'b0;
    bit            stalled    = 1'b0;
    logic [PW+1:0] held;
    exp_t          got_e;

    always @(negedge clk) begin
        if (rst) begin
            stalled  = 1'b0;
            exp_done = 1'b0;
        end else begin
            if (exp_done) begin
                check("done_after_last", done, 1);
                exp_done = 1'b0;
            end
            if (mem_rd_en) begin
                if (addr_q.size() == 0) check("rd_unexpected", 1, 0);
                else check("rd_addr", mem_addr, addr_q.pop_front());
            end
            if (pix_valid) begin
                if (stalled) check("stall_hold", {pix_data, pix_blk_last, pix_last}, held);
                if (pix_ready) begin
                    stalled = 1'b0;
                    if (pix_q.size() == 0) begin
                        check("pix_unexpected", 1, 0);
                    end else begin
                        got_e = pix_q.pop_front();
                        check("pix_data", pix_data, got_e.data);
                        check("pix_blk_last", pix_blk_last, got_e.blk_last);
                        check("pix_last", pix_last, got_e.last);
                        if (got_e.last) exp_done = 1'b1;
                    end
                    hs_total++;
                end else begin
                    stalled = 1'b1;
                    held    = {pix_data, pix_blk_last, pix_last};
                end
            end else begin
                stalled = 1'b0;
            end
        end
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = stall one pixel index for stall_left cycles
    int ready_mode = 0;
    int stall_idx  = 0;
    int stall_left = 0;

    always @(posedge clk) begin
        #1;
        if (ready_mode == 1) pix_ready = 1'($urandom_range(0, 1));
        else if (ready_mode == 2 && pix_valid && (hs_total - frame_base) == stall_idx && stall_left > 0) begin
            pix_ready = 1'b0;
            stall_left--;
        end else pix_ready = 1'b1;
    end

    task automatic pulse_start(input int m, input int blocks, input int pri, input int wm,
                               input int a, input int b);
        cfg_m        = BD'(m);
        cfg_blocks   = BW'(blocks);
        cfg_pri_base = AW'(pri);
        cfg_wm_base  = AW'(wm);
        cfg_alpha    = CW'(a);
        cfg_beta     = CW'(b);
        start        = 1'b1;
        @(posedge clk);
        #1;
        start        = 1'b0;
        // Scramble configuration: the running frame must use the latched copy
        cfg_m        = BD'($urandom);
        cfg_blocks   = BW'($urandom);
        cfg_pri_base = AW'($urandom);
        cfg_wm_base  = AW'($urandom);
        cfg_alpha    = CW'($urandom);
        cfg_beta     = CW'($urandom);
    endtask

    task automatic run_frame(input int m, input int blocks, input int pri, input int wm,
                             input int a, input int b, input bit poke);
        int cyc        = 0;
        int first_vld  = -1;
        int done_cyc   = -1;
        bit empty      = (m == 0 || blocks == 0);
        frame_base = hs_total;
        if (!empty) build_model(m, blocks, pri, wm, a, b);
        @(posedge clk);
        #1;
        pulse_start(m, blocks, pri, wm, a, b);
        while (cyc < 3000 && done_cyc < 0) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (poke) start = (cyc == 1);
            if (pix_valid && first_vld < 0) first_vld = cyc;
            if (done) done_cyc = cyc;
        end
        start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 0, 1);
        if (empty) begin
            check("empty_done_latency", done_cyc, 2);
            check("empty_no_pixel", first_vld, -1);
        end else begin
            check("first_valid_latency", first_vld, 4);
            check("pixel_count", hs_total - frame_base, m * m * blocks);
        end
        @(negedge clk);
        check("busy_clear", busy, 0);
        check("done_one_cycle", done, 0);
        check("pix_q_drained", pix_q.size(), 0);
        check("addr_q_drained", addr_q.size(), 0);
    endtask

    initial begin
        int wait_cyc;
        rst          = 1'b1;
        start        = 1'b0;
        cfg_m        = '0;
        cfg_blocks   = '0;
        cfg_pri_base = '0;
        cfg_wm_base  = '0;
        cfg_alpha    = '0;
        cfg_beta     = '0;
        for (int i = 0; i < 4096; i++) mem[i] = PW'($urandom);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {mem_rd_en, mem_addr, pix_valid, pix_data, pix_blk_last, pix_last, busy, done}, 0);
        rst = 1'b0;

        // Mid-grey blend: P=100, W=200, alpha=beta=0.5
        for (int i = 0; i < 4; i++) begin
            mem[16'h10 + i] = {CH{8'd100}};
            mem[16'h30 + i] = {CH{8'd200}};
        end
        run_frame(2, 1, 'h10, 'h30, 128, 128, 0);

        // Overflow: alpha=beta=255, P=W=200
        for (int i = 0; i < 4; i++) begin
            mem[16'h50 + i] = {CH{8'd200}};
            mem[16'h60 + i] = {CH{8'd200}};
        end
        run_frame(2, 1, 'h50, 'h60, 255, 255, 0);

        // Multi-block address walk with watermark reuse
        run_frame(2, 3, 'h0A, 'h100, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);

        // Back-pressure on the second pixel
        ready_mode = 2;
        stall_idx  = 1;
        stall_left = 5;
        run_frame(2, 2, 'h200, 'h300, 77, 180, 0);
        check("stall_applied", stall_left, 0);
        ready_mode = 0;

        // Empty frames, with a start pulse while busy
        run_frame(0, 3, 'h400, 'h500, 10, 20, 1);
        run_frame(3, 0, 'h400, 'h500, 10, 20, 0);
        ready_mode = 1;
        run_frame(3, 2, 'h600, 'h700, 200, 40, 1);
        ready_mode = 0;

        // Reset while pixel 3 is held in OUT
        ready_mode = 2;
        stall_idx  = 2;
        stall_left = 1000;
        frame_base = hs_total;
        build_model(2, 1, 'h800, 'h900, 128, 128);
        @(posedge clk);
        #1;
        pulse_start(2, 1, 'h800, 'h900, 128, 128);
        wait_cyc = 0;
        do begin
            @(negedge clk);
            wait_cyc++;
        end while (!(pix_valid && (hs_total - frame_base) == 2) && wait_cyc < 200);
        if (wait_cyc >= 200) check("rst_setup_timeout", 0, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midframe_reset_outputs", {mem_rd_en, mem_addr, pix_valid, pix_data, pix_blk_last, pix_last, busy, done}, 0);
        pix_q.delete();
        addr_q.delete();
        stall_left = 0;
        ready_mode = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("no_done_after_reset", {done, busy, pix_valid, mem_rd_en}, 0);
        end
        run_frame(2, 2, 'h800, 'h900, 128, 128, 0);

        // Randomized frames under random back-pressure
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            run_frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 2000)), int'($urandom_range(2100, 3900)),
                      int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
        end
        ready_mode = 0;

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
